instr_mem_loader: RTL

Boot-time program loader for the single-cycle CPU. It receives a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into instruction memory through a write port. It holds the CPU in reset while loading and releases it only after the frame checksum verifies. It is the writer-side counterpart of the CPU's instruction fetch path and replaces file-based memory initialisation on hardware.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/instr_word_packer.sv | 44 ++++
 rtl/instr_mem_loader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction word width, loader frame marker and the
// loader state encoding. Imported by the loader, its word packer and the CPU's
// instruction memory.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_RUN,
    ST_ERR
  } loader_state_e;

endpackage

// File: rtl/instr_word_packer.sv
// Assembles four stream bytes into one little-endian instruction word.
// Ports:
//   clk_i, rst_n  clock, asynchronous active-low reset
//   clear         restart at lane 0 (start of a new frame)
//   strobe        a data byte is being accepted this cycle
//   data          the byte being accepted
//   word          assembled word; valid while word_ready is high
//   word_ready    high in the cycle lane 3 is accepted
module instr_word_packer
  import cpu_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               strobe,
  input  logic [7:0]         data,
  output logic [INSTR_W-1:0] word,
  output logic               word_ready
);

  logic [1:0]  lane;
  logic [23:0] lower;  // bytes of lanes 0..2, lane 0 ends up in bits [7:0]

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      lane  <= 2'd0;
      lower <= 24'd0;
    end else if (clear) begin
      lane  <= 2'd0;
      lower <= 24'd0;
    end else if (strobe) begin
      lane  <= lane + 2'd1;  // wraps 3 -> 0 after a completed word
      lower <= {data, lower[23:8]};
    end
  end

  // The lane-3 byte is not stored; the word is completed combinationally and
  // captured by the loader's write register on the same edge.
  assign word       = {data, lower};
  assign word_ready = strobe && (lane == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// Boot-time program loader. Receives a framed byte stream
// (SYNC, LEN_HI, LEN_LO, 4*LEN data bytes LSB first, CSUM), writes the words
// to instruction memory from address 0 and releases the CPU only after the
// XOR checksum matches.
// Ports:
//   clk_i, rst_n            clock, asynchronous active-low reset
//   in_data_i/valid/ready   byte stream handshake
//   im_we_o/addr_o/data_o   registered instruction-memory write port
//   cpu_rst_n_o             CPU reset, high only when a program is loaded
//   done_o                  program loaded, CPU running
//   err_o                   last frame rejected
module instr_mem_loader
  import cpu_pkg::*;
#(
  parameter int         IM_AW     = 7,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic [7:0]         in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic               im_we_o,
  output logic [IM_AW-1:0]   im_addr_o,
  output logic [INSTR_W-1:0] im_data_o,
  output logic               cpu_rst_n_o,
  output logic               done_o,
  output logic               err_o
);

  localparam logic [16:0] DEPTH = 17'(2 ** IM_AW);

  loader_state_e      state;
  logic [7:0]         len_hi;
  logic [15:0]        len;
  logic [15:0]        word_cnt;
  logic [7:0]         csum;

  logic               accept;
  logic               is_sync;
  logic               frame_start;
  logic               pack_strobe;
  logic [INSTR_W-1:0] pack_word;
  logic               pack_ready;
  logic [15:0]        len_word;

  // NOTE: in_ready_o is a direct function of the registered write strobe, so
  // it is glitch-free and blocks a byte only in the write cycle.
  assign in_ready_o  = !im_we_o;
  assign accept      = in_valid_i && in_ready_o;
  assign is_sync     = (in_data_i == SYNC_BYTE);
  assign frame_start = accept && is_sync &&
                       (state == ST_IDLE || state == ST_RUN || state == ST_ERR);
  assign pack_strobe = accept && (state == ST_DATA);
  assign len_word    = {len_hi, in_data_i};

  instr_word_packer u_packer (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .clear      (frame_start),
    .strobe     (pack_strobe),
    .data       (in_data_i),
    .word       (pack_word),
    .word_ready (pack_ready)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      len_hi      <= 8'd0;
      len         <= 16'd0;
      word_cnt    <= 16'd0;
      csum        <= 8'd0;
      im_we_o     <= 1'b0;
      im_addr_o   <= '0;
      im_data_o   <= '0;
      cpu_rst_n_o <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      im_we_o <= 1'b0;

      // Any accepted sync outside a frame restarts loading; the CPU is put
      // back into reset and the status flags clear on the same edge.
      if (frame_start) begin
        state       <= ST_LEN_HI;
        csum        <= 8'd0;
        word_cnt    <= 16'd0;
        done_o      <= 1'b0;
        err_o       <= 1'b0;
        cpu_rst_n_o <= 1'b0;
      end else if (accept) begin
        case (state)
          ST_LEN_HI: begin
            len_hi <= in_data_i;
            csum   <= csum ^ in_data_i;
            state  <= ST_LEN_LO;
          end
          ST_LEN_LO: begin
            len  <= len_word;
            csum <= csum ^ in_data_i;
            if ({1'b0, len_word} > DEPTH) begin
              state <= ST_ERR;
              err_o <= 1'b1;
            end else if (len_word == 16'd0) begin
              state <= ST_CSUM;
            end else begin
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            csum <= csum ^ in_data_i;
            if (pack_ready) begin
              im_we_o   <= 1'b1;
              im_addr_o <= word_cnt[IM_AW-1:0];
              im_data_o <= pack_word;
              word_cnt  <= word_cnt + 16'd1;
              if (word_cnt == len - 16'd1) state <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            if (in_data_i == csum) begin
              state       <= ST_RUN;
              done_o      <= 1'b1;
              cpu_rst_n_o <= 1'b1;
            end else begin
              state <= ST_ERR;
              err_o <= 1'b1;
            end
          end
          default: ;  // IDLE, RUN, ERR: non-sync bytes are discarded
        endcase
      end
    end
  end

endmodule
